// File: rtl/vcore_ppln_pkg.sv
// Shared definitions for the vcore pipeline stage and its downstream elastic FIFO.
package vcore_ppln_pkg;

  localparam int unsigned DefaultDepth = 4;
  localparam int unsigned DefaultCtrlW = 8;
  localparam int unsigned DefaultDataW = 64;

  // Pointer width including the wrap bit that separates full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [DefaultCtrlW-1:0] ctrl;
    logic [DefaultDataW-1:0] data;
  } beat_t;

endpackage

// File: rtl/vcore_ppln_fifo_ptr.sv
// FIFO pointer with wrap bit; reports either full or empty against the peer pointer.
module vcore_ppln_fifo_ptr #(
  parameter int unsigned PtrW    = 3,
  parameter bit          CmpFull = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            inc,
  input  logic [PtrW-1:0] peer_ptr,
  output logic [PtrW-1:0] ptr,
  output logic            hit
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    if (CmpFull) begin
      hit = (ptr_q[PtrW-2:0] == peer_ptr[PtrW-2:0]) && (ptr_q[PtrW-1] != peer_ptr[PtrW-1]);
    end else begin
      hit = (ptr_q == peer_ptr);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/vcore_ppln_fifo.sv
// FWFT elastic FIFO behind a vcore pipeline stage: count, almost_full, synchronous flush.
// Define VCORE_PPLN_FIFO_STATS_EN to add the max_count high-water-mark output.
module vcore_ppln_fifo
  import vcore_ppln_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH   = DefaultCtrlW,
  parameter int unsigned DATA_WIDTH   = DefaultDataW,
  parameter int unsigned DEPTH        = DefaultDepth,
  parameter int unsigned AFULL_THRESH = 3,
  parameter int unsigned CNT_W        = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full
`ifdef VCORE_PPLN_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]      max_count
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] AfullThr = CNT_W'(AFULL_THRESH);

  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop, wr_en;
  logic [CNT_W-1:0] count_q, count_d;
  logic             almost_full_q, almost_full_d;

  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
  logic [CTRL_WIDTH-1:0] ctrl_mem_q [DEPTH];
  logic [CTRL_WIDTH-1:0] ctrl_mem_d [DEPTH];

  assign ready_out = ~full;
  assign valid_out = ~empty;
  assign push      = valid_in & ready_out;
  assign pop       = valid_out & ready_in;
  // Flush drops the push of its own cycle, so it must not touch storage either.
  assign wr_en     = push & ~flush;

  vcore_ppln_fifo_ptr #(
    .PtrW    (CNT_W),
    .CmpFull (1'b1)
  ) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .inc      (push),
    .peer_ptr (rd_ptr),
    .ptr      (wr_ptr),
    .hit      (full)
  );

  vcore_ppln_fifo_ptr #(
    .PtrW    (CNT_W),
    .CmpFull (1'b0)
  ) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .inc      (pop),
    .peer_ptr (wr_ptr),
    .ptr      (rd_ptr),
    .hit      (empty)
  );

  always_comb begin
    data_mem_d = data_mem_q;
    ctrl_mem_d = ctrl_mem_q;
    if (wr_en) begin
      data_mem_d[wr_ptr[IdxW-1:0]] = data_in;
      ctrl_mem_d[wr_ptr[IdxW-1:0]] = ctrl_in;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    almost_full_d = (count_d >= AfullThr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      almost_full_q <= 1'b0;
      ctrl_mem_q    <= '{default: '0};
    end else begin
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      ctrl_mem_q    <= ctrl_mem_d;
    end
  end

  // Data payload is deliberately left unreset; consumers qualify it with valid_out.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
  end

  assign data_out    = data_mem_q[rd_ptr[IdxW-1:0]];
  assign ctrl_out    = ctrl_mem_q[rd_ptr[IdxW-1:0]];
  assign count       = count_q;
  assign almost_full = almost_full_q;

`ifdef VCORE_PPLN_FIFO_STATS_EN
  logic [CNT_W-1:0] max_count_q, max_count_d;

  always_comb begin
    max_count_d = max_count_q;
    if (count_d > max_count_q) begin
      max_count_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_count_q <= '0;
    end else begin
      max_count_q <= max_count_d;
    end
  end

  assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_vcore_ppln_fifo.sv
// Randomised bench for vcore_ppln_fifo against a queue-based reference model.
module tb_vcore_ppln_fifo;

  localparam int unsigned CW    = 8;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned CNT_W = 3;

  logic          clk = 1'b0;
  logic          rst, flush, valid_in, ready_in;
  logic          ready_out, valid_out, almost_full;
  logic [DW-1:0] data_in, data_out;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [CNT_W-1:0] count;
`ifdef VCORE_PPLN_FIFO_STATS_EN
  logic [CNT_W-1:0] max_count;
`endif

  vcore_ppln_fifo #(
    .CTRL_WIDTH   (CW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_in     (data_in),
    .ctrl_in     (ctrl_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .data_out    (data_out),
    .ctrl_out    (ctrl_out),
    .count       (count),
    .almost_full (almost_full)
`ifdef VCORE_PPLN_FIFO_STATS_EN
    ,
    .max_count   (max_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t m_q[$];
  int    m_max = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a bounded queue updated with the handshake rules each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_max = 0;
    end else if (flush) begin
      m_q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = valid_in && (m_q.size() < DEPTH);
      do_pop  = ready_in && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back('{c: ctrl_in, d: data_in});
      if (m_q.size() > m_max) m_max = m_q.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("valid_out", 64'(valid_out), 64'(m_q.size() > 0));
      cmp("ready_out", 64'(ready_out), 64'(m_q.size() < DEPTH));
      cmp("count", 64'(count), 64'(m_q.size()));
      cmp("almost_full", 64'(almost_full), 64'(m_q.size() >= AF));
      if (m_q.size() > 0) begin
        cmp("data_out", data_out, m_q[0].d);
        cmp("ctrl_out", 64'(ctrl_out), 64'(m_q[0].c));
      end
`ifdef VCORE_PPLN_FIFO_STATS_EN
      cmp("max_count", 64'(max_count), 64'(m_max));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bd [4];
    logic [1:0]    af_exp [4];
    logic [DW-1:0] last_d;

    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    data_in = '0; ctrl_in = '0;
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset then idle.
    step();
    cmp("t1_valid", 64'(valid_out), 64'd0);
    cmp("t1_ready", 64'(ready_out), 64'd1);
    cmp("t1_count", 64'(count), 64'd0);
    cmp("t1_afull", 64'(almost_full), 64'd0);
    cmp("t1_ctrl", 64'(ctrl_out), 64'd0);
`ifdef VCORE_PPLN_FIFO_STATS_EN
    cmp("t1_max", 64'(max_count), 64'd0);
`endif

    // Fill to full with the consumer stalled.
    af_exp[0] = 2'd0; af_exp[1] = 2'd0; af_exp[2] = 2'd1; af_exp[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in  = 64'hA1 + 64'(i);
      ctrl_in  = 8'hA1 + 8'(i);
      step();
      cmp("t2_count", 64'(count), 64'(i + 1));
      cmp("t2_afull", 64'(almost_full), 64'(af_exp[i]));
    end
    cmp("t2_ready_full", 64'(ready_out), 64'd0);
    data_in = 64'hA5; ctrl_in = 8'hA5;
    step();
    cmp("t2_count_5th", 64'(count), 64'd4);
    cmp("t2_head", data_out, 64'hA1);

    // Drain from full while upstream keeps offering.
    bd[0] = 64'hA2; bd[1] = 64'hA3; bd[2] = 64'hA4; bd[3] = 64'hB1;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 64'hB0 + 64'(i);
      ctrl_in = 8'hB0 + 8'(i);
      step();
      cmp("t3_head", data_out, bd[i]);
      cmp("t3_count", 64'(count), 64'd3);
      if (i == 0) cmp("t3_ready_after_pop", 64'(ready_out), 64'd1);
    end
    valid_in = 1'b0;
    for (int i = 0; i < 8 && valid_out; i++) step();
    cmp("t3_drain", 64'(valid_out), 64'd0);

    // Streaming with pointer wrap.
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1;
      data_in  = {$urandom, $urandom};
      ctrl_in  = 8'($urandom);
      last_d   = data_in;
      step();
      cmp("t4_count", 64'(count), 64'd1);
      cmp("t4_data", data_out, last_d);
    end
    valid_in = 1'b0;
    step();
    cmp("t4_empty", 64'(count), 64'd0);

    // Flush with a simultaneous push.
    ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; data_in = 64'hC1 + 64'(i); ctrl_in = 8'hC1 + 8'(i);
      step();
    end
    cmp("t5_count_pre", 64'(count), 64'd2);
    flush = 1'b1; data_in = 64'hEE; ctrl_in = 8'hEE;
    step();
    flush = 1'b0; valid_in = 1'b0;
    cmp("t5_count", 64'(count), 64'd0);
    cmp("t5_valid", 64'(valid_out), 64'd0);
    cmp("t5_afull", 64'(almost_full), 64'd0);
    step();
    cmp("t5_valid_later", 64'(valid_out), 64'd0);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 64'hD1 + 64'(i); ctrl_in = 8'hD1 + 8'(i);
      step();
    end
    cmp("t6_count_pre", 64'(count), 64'd3);
`ifdef VCORE_PPLN_FIFO_STATS_EN
    cmp("t6_max_pre", 64'(max_count), 64'd4);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0; valid_in = 1'b0;
    cmp("t6_valid", 64'(valid_out), 64'd0);
    cmp("t6_count", 64'(count), 64'd0);
    cmp("t6_ctrl", 64'(ctrl_out), 64'd0);
    cmp("t6_ready", 64'(ready_out), 64'd1);
`ifdef VCORE_PPLN_FIFO_STATS_EN
    cmp("t6_max", 64'(max_count), 64'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 31) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      data_in  = {$urandom, $urandom};
      ctrl_in  = 8'($urandom);
      step();
    end
    valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0; rst = 1'b0;
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
